i2s_codec_model: RTL and testbench

- Synthesizable codec-side (slave) endpoint of the left-justified audio serial link driven by the FPGA codec master.
- Receives AUD_BCLK, AUD_DACLRCK and AUD_DACDAT, and deserializes them into 16-bit left/right DAC words.
- Serializes supplied ADC words onto AUD_ADCDAT.
- Used for on-chip loopback and codec-less bring-up of the audio path.

---
 rtl/i2s_codec_model.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_i2s_codec_model.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_codec_model.sv
// i2s_codec_model: codec-side (slave) endpoint of a left-justified serial
// audio link. It deserializes AUD_DACDAT into left/right DAC words and
// serializes ADC word pairs onto AUD_ADCDAT.
// Optional macro I2S_MODEL_SYNC_EN: adds a 2-flop synchronizer on the serial
// inputs for an asynchronous master. When it is undefined, a single capture
// stage is used for a same-clock master.
module i2s_codec_model #(
    parameter int WORD_BITS = 16,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 AUD_BCLK,
    input  logic                 AUD_DACLRCK,
    input  logic                 AUD_DACDAT,
    output logic                 AUD_ADCDAT,
    output logic [WORD_BITS-1:0] dac_l,
    output logic [WORD_BITS-1:0] dac_r,
    output logic                 dac_valid,
    input  logic [WORD_BITS-1:0] adc_l,
    input  logic [WORD_BITS-1:0] adc_r,
    input  logic                 adc_valid,
    output logic                 adc_ready,
    output logic                 underrun,
    output logic                 short_frame,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bit 3 is a constant 1 that travels with the samples, so edges are only
    // trusted once both the current and delayed copies hold real samples.
    logic [3:0] in_raw_s;
    logic [3:0] in_cur_r;
    logic [2:0] in_prev_r;

    assign in_raw_s = {1'b1, AUD_DACDAT, AUD_DACLRCK, AUD_BCLK};

`ifdef I2S_MODEL_SYNC_EN
    logic [3:0] in_meta_r;

    // Two-flop synchronizer for an asynchronous master
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_meta_r <= 4'b0000;
            in_cur_r  <= 4'b0000;
        end else begin
            in_meta_r <= in_raw_s;
            in_cur_r  <= in_meta_r;
        end
    end
`else
    // Single capture stage for a same-clock master
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cur_r <= 4'b0000;
        end else begin
            in_cur_r <= in_raw_s;
        end
    end
`endif

    // Delayed copy of valid/LRCK/BCLK for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_prev_r <= 3'b000;
        end else begin
            in_prev_r <= {in_cur_r[3], in_cur_r[1], in_cur_r[0]};
        end
    end

    logic vld_s, rise_s, fall_s, ledge_s, lrck_s, dat_s;

    assign vld_s   = in_cur_r[3] & in_prev_r[2];
    assign rise_s  = vld_s &  in_cur_r[0] & ~in_prev_r[0];
    assign fall_s  = vld_s & ~in_cur_r[0] &  in_prev_r[0];
    assign ledge_s = vld_s & (in_cur_r[1] ^ in_prev_r[1]);
    assign lrck_s  = in_cur_r[1];
    assign dat_s   = in_cur_r[2];

    state_t state_r, state_nxt_s;
    logic   left_start_s, left_end_s, right_end_s, in_frame_s;

    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [WORD_BITS-1:0] shin_r, shin_nxt_s;
    logic [WORD_BITS-1:0] stage_r, stage_nxt_s;
    logic [WORD_BITS-1:0] dac_l_r, dac_l_nxt_s;
    logic [WORD_BITS-1:0] dac_r_r, dac_r_nxt_s;
    logic                 dac_valid_r, dac_valid_nxt_s;
    logic                 short_set_s;

    logic [WORD_BITS-1:0] hold_l_r, hold_l_nxt_s;
    logic [WORD_BITS-1:0] hold_r_r, hold_r_nxt_s;
    logic                 full_r, full_nxt_s;
    logic [WORD_BITS-1:0] tx_l_r, tx_l_nxt_s;
    logic [WORD_BITS-1:0] tx_r_r, tx_r_nxt_s;
    logic [WORD_BITS-1:0] shout_r, shout_nxt_s;
    logic                 under_set_s;
    logic                 accept_s;

    logic under_r, under_nxt_s;
    logic short_r, short_nxt_s;
    logic adcdat_r, adcdat_nxt_s;
    logic adc_ready_r, adc_ready_nxt_s;

    assign accept_s = adc_valid & ~full_r;

    // Framing FSM register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Framing FSM next state and half-frame boundary strobes
    always_comb begin
        state_nxt_s  = state_r;
        left_start_s = 1'b0;
        left_end_s   = 1'b0;
        right_end_s  = 1'b0;
        in_frame_s   = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (ledge_s && lrck_s) begin
                    state_nxt_s  = ST_LEFT;
                    left_start_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_SYNC;
                end
            end
            ST_LEFT: begin
                in_frame_s = 1'b1;
                if (ledge_s) begin
                    state_nxt_s = ST_RIGHT;
                    left_end_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                in_frame_s = 1'b1;
                if (ledge_s) begin
                    state_nxt_s  = ST_LEFT;
                    right_end_s  = 1'b1;
                    left_start_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_RIGHT;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase
    end

    // Receive path: bit counter, input shifter, left staging, DAC word update
    always_comb begin
        cnt_nxt_s       = cnt_r;
        shin_nxt_s      = shin_r;
        stage_nxt_s     = stage_r;
        dac_l_nxt_s     = dac_l_r;
        dac_r_nxt_s     = dac_r_r;
        dac_valid_nxt_s = 1'b0;
        short_set_s     = 1'b0;
        if (ledge_s && (in_frame_s || left_start_s)) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            shin_nxt_s = {WORD_BITS{1'b0}};
        end else if (in_frame_s && rise_s && (cnt_r < WORD_CNT)) begin
            shin_nxt_s = {shin_r[WORD_BITS-2:0], dat_s};
            cnt_nxt_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        end else begin
            cnt_nxt_s  = cnt_r;
        end
        if (left_end_s) begin
            if (cnt_r == WORD_CNT) begin
                stage_nxt_s = shin_r;
            end else begin
                short_set_s = 1'b1;
            end
        end else if (right_end_s) begin
            if (cnt_r == WORD_CNT) begin
                dac_l_nxt_s     = stage_r;
                dac_r_nxt_s     = shin_r;
                dac_valid_nxt_s = 1'b1;
            end else begin
                short_set_s = 1'b1;
            end
        end else begin
            stage_nxt_s = stage_r;
        end
    end

    // Transmit path: holding register, pair reload at LEFT start, output shifter
    always_comb begin
        hold_l_nxt_s = hold_l_r;
        hold_r_nxt_s = hold_r_r;
        full_nxt_s   = full_r;
        tx_l_nxt_s   = tx_l_r;
        tx_r_nxt_s   = tx_r_r;
        shout_nxt_s  = shout_r;
        under_set_s  = 1'b0;
        if (left_start_s) begin
            if (full_r) begin
                shout_nxt_s = hold_l_r;
                tx_l_nxt_s  = hold_l_r;
                tx_r_nxt_s  = hold_r_r;
                full_nxt_s  = 1'b0;
            end else begin
                shout_nxt_s = tx_l_r;
                under_set_s = 1'b1;
            end
        end else if (left_end_s) begin
            shout_nxt_s = tx_r_r;
        end else if (in_frame_s && fall_s) begin
            shout_nxt_s = {shout_r[WORD_BITS-2:0], 1'b0};
        end else begin
            shout_nxt_s = shout_r;
        end
        // The accept is applied after the LEFT load so a same-cycle offer
        // is held for the following frame.
        if (accept_s) begin
            hold_l_nxt_s = adc_l;
            hold_r_nxt_s = adc_r;
            full_nxt_s   = 1'b1;
        end else begin
            hold_l_nxt_s = hold_l_nxt_s;
        end
    end

    // Sticky flags (a set wins over err_clr), next serial bit and ready
    always_comb begin
        under_nxt_s     = under_set_s | (under_r & ~err_clr);
        short_nxt_s     = short_set_s | (short_r & ~err_clr);
        adcdat_nxt_s    = (state_nxt_s != ST_SYNC) && (cnt_nxt_s < WORD_CNT) &&
                          shout_nxt_s[WORD_BITS-1];
        adc_ready_nxt_s = ~full_nxt_s;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            shin_r      <= {WORD_BITS{1'b0}};
            stage_r     <= {WORD_BITS{1'b0}};
            dac_l_r     <= {WORD_BITS{1'b0}};
            dac_r_r     <= {WORD_BITS{1'b0}};
            dac_valid_r <= 1'b0;
            hold_l_r    <= {WORD_BITS{1'b0}};
            hold_r_r    <= {WORD_BITS{1'b0}};
            full_r      <= 1'b0;
            tx_l_r      <= {WORD_BITS{1'b0}};
            tx_r_r      <= {WORD_BITS{1'b0}};
            shout_r     <= {WORD_BITS{1'b0}};
            under_r     <= 1'b0;
            short_r     <= 1'b0;
            adcdat_r    <= 1'b0;
            adc_ready_r <= 1'b1;
        end else begin
            cnt_r       <= cnt_nxt_s;
            shin_r      <= shin_nxt_s;
            stage_r     <= stage_nxt_s;
            dac_l_r     <= dac_l_nxt_s;
            dac_r_r     <= dac_r_nxt_s;
            dac_valid_r <= dac_valid_nxt_s;
            hold_l_r    <= hold_l_nxt_s;
            hold_r_r    <= hold_r_nxt_s;
            full_r      <= full_nxt_s;
            tx_l_r      <= tx_l_nxt_s;
            tx_r_r      <= tx_r_nxt_s;
            shout_r     <= shout_nxt_s;
            under_r     <= under_nxt_s;
            short_r     <= short_nxt_s;
            adcdat_r    <= adcdat_nxt_s;
            adc_ready_r <= adc_ready_nxt_s;
        end
    end

    assign AUD_ADCDAT  = adcdat_r;
    assign dac_l       = dac_l_r;
    assign dac_r       = dac_r_r;
    assign dac_valid   = dac_valid_r;
    assign adc_ready   = adc_ready_r;
    assign underrun    = under_r;
    assign short_frame = short_r;

endmodule

// File: tb/tb_i2s_codec_model.sv
// Self-checking bench for i2s_codec_model: a behavioural master drives the
// serial link and captures AUD_ADCDAT, while a frame-level model predicts
// DAC word pairs, transmitted words and sticky flags.
module tb_i2s_codec_model;
    localparam int W = 16;
`ifdef I2S_MODEL_SYNC_EN
    localparam int HALF = 4;
    localparam int SKEW = 3;
`else
    localparam int HALF = 2;
    localparam int SKEW = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bclk = 1'b0, lrck = 1'b0, dacdat = 1'b0;
    logic          adcdat;
    logic [W-1:0]  dac_l, dac_r;
    logic          dac_valid;
    logic [W-1:0]  adc_l = 16'h0000, adc_r = 16'h0000;
    logic          adc_valid = 1'b0;
    logic          adc_ready, underrun, short_frame;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    i2s_codec_model #(.WORD_BITS(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dacdat),
        .AUD_ADCDAT(adcdat),
        .dac_l(dac_l), .dac_r(dac_r), .dac_valid(dac_valid),
        .adc_l(adc_l), .adc_r(adc_r), .adc_valid(adc_valid),
        .adc_ready(adc_ready), .underrun(underrun), .short_frame(short_frame),
        .err_clr(err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model state
    logic [W-1:0]  m_stage = 16'h0000, m_last_l = 16'h0000, m_last_r = 16'h0000;
    logic [W-1:0]  m_hold_l = 16'h0000, m_hold_r = 16'h0000;
    bit            m_full = 1'b0, m_under = 1'b0, m_short = 1'b0, m_sync = 1'b1;
    logic [31:0]   exp_q[$];
    logic [W-1:0]  cur_l = 16'h0000, cur_r = 16'h0000;
    logic [W-1:0]  prev_word = 16'h0000;
    int            prev_n = 0;
    int            pulses = 0;
    logic [31:0]   last_cap = 32'h0;

    task automatic tick();
        @(posedge clk);
        #SKEW;
    endtask

    // Effect of an LRCK edge on the model, lr being the new LRCK level
    task automatic model_ledge(input bit lr);
        if (!m_sync) begin
            if (!lr) begin
                if (prev_n >= W) m_stage = prev_word;
                else m_short = 1'b1;
            end else begin
                if (prev_n >= W) exp_q.push_back({m_stage, prev_word});
                else m_short = 1'b1;
            end
        end
        if (lr) begin
            m_sync = 1'b0;
            if (m_full) begin
                m_last_l = m_hold_l;
                m_last_r = m_hold_r;
                m_full   = 1'b0;
            end else begin
                m_under = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_stage = 16'h0000; m_last_l = 16'h0000; m_last_r = 16'h0000;
        m_full = 1'b0; m_under = 1'b0; m_short = 1'b0; m_sync = 1'b1;
        exp_q.delete();
        cur_l = 16'h0000; cur_r = 16'h0000;
        pulses = 0;
    endtask

    // One half-frame of n bits; optional ADC offer / err_clr at bit off_i / clr_i
    task automatic send_half(input bit lr, input logic [W-1:0] word, input int n,
                             input int off_i, input logic [W-1:0] off_l,
                             input logic [W-1:0] off_r, input int clr_i, input bit chk);
        logic [31:0] cap, expv;
        logic [W-1:0] expw;
        bit led;
        int idx;
        led = (lr != lrck);
        if (led) model_ledge(lr);
        expw = m_sync ? 16'h0000 : (lr ? m_last_l : m_last_r);
        cap = 32'h0;
        expv = 32'h0;
        for (int i = 0; i < n; i++) begin
            idx = (i < W) ? (W - 1 - i) : 0;
            tick();
            bclk = 1'b0;
            lrck = lr;
            dacdat = (i < W) ? word[idx] : 1'($urandom);
            expv = {expv[30:0], (i < W) ? expw[idx] : 1'b0};
            for (int k = 1; k < HALF; k++) begin
                tick();
                if (k == 1 && i == off_i) begin
                    if (i != 0) check("adc_ready_pre", {31'd0, adc_ready}, {31'd0, !m_full});
                    adc_l = off_l;
                    adc_r = off_r;
                    adc_valid = 1'b1;
                    if (!m_full) begin
                        m_hold_l = off_l;
                        m_hold_r = off_r;
                        m_full = 1'b1;
                    end
                end
                if (k == 1 && i == clr_i) begin
                    err_clr = 1'b1;
                    m_under = 1'b0;
                    m_short = 1'b0;
                end
            end
            tick();
            bclk = 1'b1;
            adc_valid = 1'b0;
            err_clr = 1'b0;
            tick();
            cap = {cap[30:0], adcdat};
            for (int k = 2; k < HALF; k++) tick();
        end
        if (chk) begin
            check("adc_bits", cap, expv);
            check("underrun", {31'd0, underrun}, {31'd0, m_under});
            check("short_frame", {31'd0, short_frame}, {31'd0, m_short});
            check("adc_ready", {31'd0, adc_ready}, {31'd0, !m_full});
        end
        last_cap = cap;
        if (led) begin
            prev_word = word;
            prev_n = n;
        end else begin
            prev_n = prev_n + n;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] wl, input logic [W-1:0] wr,
                              input int nl, input int nr);
        send_half(1'b1, wl, nl, -1, 16'h0000, 16'h0000, -1, 1'b1);
        send_half(1'b0, wr, nr, -1, 16'h0000, 16'h0000, -1, 1'b1);
    endtask

    // Per-cycle comparison of the DAC outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (dac_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("dac_valid_spurious", {31'd0, dac_valid}, 32'd0);
                end else begin
                    {cur_l, cur_r} = exp_q.pop_front();
                end
            end
            check("dac_l", {16'd0, dac_l}, {16'd0, cur_l});
            check("dac_r", {16'd0, dac_r}, {16'd0, cur_r});
        end
    end

    initial begin
        #5_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [W-1:0] cl, wl, wr;
        int nl, nr;
        repeat (5) @(posedge clk);
        #SKEW;
        // Reset values
        check("rst_adcdat", {31'd0, adcdat}, 32'd0);
        check("rst_dac_l", {16'd0, dac_l}, 32'd0);
        check("rst_dac_r", {16'd0, dac_r}, 32'd0);
        check("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
        check("rst_adc_ready", {31'd0, adc_ready}, 32'd1);
        check("rst_flags", {30'd0, underrun, short_frame}, 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Pair offered while still in SYNC
        adc_l = 16'h8001; adc_r = 16'h7FFE; adc_valid = 1'b1;
        m_hold_l = 16'h8001; m_hold_r = 16'h7FFE; m_full = 1'b1;
        tick();
        adc_valid = 1'b0;
        send_half(1'b0, 16'hFFFF, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);

        // Frame 1: A5C3 / 0F1E; 1234/5678 offered mid right half
        send_half(1'b1, 16'hA5C3, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        cl = last_cap[15:0];
        send_half(1'b0, 16'h0F1E, 16, 4, 16'h1234, 16'h5678, -1, 1'b1);
        check("s2_cap_l", {16'd0, cl}, 32'h8001);
        check("s2_cap_r", last_cap, 32'h7FFE);
        check("s2_underrun", {31'd0, underrun}, 32'd0);

        // Frame 2 transmits 1234/5678; frames 3 and 4 must retransmit it
        send_half(1'b1, 16'h1357, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        check("s1_dac_l", {16'd0, dac_l}, 32'hA5C3);
        check("s1_dac_r", {16'd0, dac_r}, 32'h0F1E);
        check("s1_pulses", pulses, 32'd1);
        send_half(1'b0, 16'h2468, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        send_frame(16'h3333, 16'h4444, 16, 16);
        send_half(1'b1, 16'h5555, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        check("s3_cap_l", last_cap, 32'h1234);
        send_half(1'b0, 16'h6666, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        check("s3_cap_r", last_cap, 32'h5678);
        check("s3_underrun", {31'd0, underrun}, 32'd1);

        // Frame 5: err_clr mid left, then a 10-bit right half
        send_half(1'b1, 16'hCAFE, 16, -1, 16'h0000, 16'h0000, 6, 1'b1);
        check("s3_underrun_clr", {31'd0, underrun}, 32'd0);
        send_half(1'b0, 16'hBEEF, 10, -1, 16'h0000, 16'h0000, -1, 1'b1);

`ifndef I2S_MODEL_SYNC_EN
        // Frame 6: offer coincides with the LEFT load
        send_half(1'b1, 16'h0101, 16, 0, 16'h9ABC, 16'hDEF0, -1, 1'b1);
`else
        send_half(1'b1, 16'h0101, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
`endif
        check("s4_short", {31'd0, short_frame}, 32'd1);
        check("s4_dac_r_kept", {16'd0, dac_r}, 32'h6666);
        send_half(1'b0, 16'h0202, 16, -1, 16'h0000, 16'h0000, 6, 1'b1);
        send_half(1'b1, 16'h0303, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
`ifndef I2S_MODEL_SYNC_EN
        check("s6_cap_l", last_cap, 32'h9ABC);
`endif
        send_half(1'b0, 16'h0404, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);

        // Reset mid left half, released mid right half
        fork
            send_half(1'b1, 16'h7777, 16, -1, 16'h0000, 16'h0000, -1, 1'b0);
            begin
                repeat (20) tick();
                reset = 1'b1;
                model_reset();
            end
        join
        fork
            send_half(1'b0, 16'h8888, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
            begin
                repeat (20) tick();
                reset = 1'b0;
            end
        join
        send_frame(16'h1A2B, 16'h3C4D, 16, 16);
        check("s5_no_pulse_yet", pulses, 32'd0);
        send_half(1'b1, 16'h5E6F, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        check("s5_pulses", pulses, 32'd1);
        check("s5_dac_l", {16'd0, dac_l}, 32'h1A2B);
        check("s5_dac_r", {16'd0, dac_r}, 32'h3C4D);
        send_half(1'b0, 16'h7081, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            wl = 16'($urandom);
            wr = 16'($urandom);
            nl = $urandom_range(0, 9);
            nr = $urandom_range(0, 9);
            nl = (nl == 0) ? 10 : (nl == 1) ? 20 : (nl == 2) ? 24 : 16;
            nr = (nr == 0) ? 12 : (nr == 1) ? 18 : (nr == 2) ? 24 : 16;
            send_half(1'b1, wl, nl,
                      ($urandom_range(0, 1) == 0) ? 4 : -1, 16'($urandom), 16'($urandom),
                      ($urandom_range(0, 6) == 0) ? 6 : -1, 1'b1);
            send_half(1'b0, wr, nr,
                      ($urandom_range(0, 2) == 0) ? 4 : -1, 16'($urandom), 16'($urandom),
                      ($urandom_range(0, 6) == 0) ? 6 : -1, 1'b1);
        end
        send_half(1'b1, 16'h0000, 16, -1, 16'h0000, 16'h0000, -1, 1'b1);
        repeat (10) tick();
        check("dac_pending", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
